// File: rtl/snake_ctrl.sv
// rtl/snake_ctrl.sv - snake head movement controller
//
// Purpose: divides frame_tick down to a step rate, arbitrates button requests
// into a legal direction (no 180-degree reversal), advances the head one cell
// per step, detects wall collisions and runs the IDLE/RUN/DEAD game state.
//
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   frame_tick            - one-cycle pulse per video frame
//   start                 - begin game (IDLE) or restart (DEAD)
//   btn_up/down/left/right - level direction requests, priority up>down>left>right
//   head_x, head_y        - head top-left coordinate
//   direction             - 000 stop, 001 up, 010 down, 011 left, 100 right
//   step                  - one-cycle pulse when the head moved
//   running, game_over    - high in RUN / DEAD
module snake_ctrl #(
  parameter int SIZE           = 25,
  parameter int BIT            = 10,
  parameter int X_START        = 300,
  parameter int Y_START        = 300,
  parameter int X_MAX          = 640,
  parameter int Y_MAX          = 480,
  parameter int TICKS_PER_STEP = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           frame_tick,
  input  logic           start,
  input  logic           btn_up,
  input  logic           btn_down,
  input  logic           btn_left,
  input  logic           btn_right,
  output logic [BIT-1:0] head_x,
  output logic [BIT-1:0] head_y,
  output logic [2:0]     direction,
  output logic           step,
  output logic           running,
  output logic           game_over
);

  localparam int CW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICKS_PER_STEP - 1);

  // Collision arithmetic is one bit wider than the coordinates so sums never wrap.
  localparam logic [BIT:0] SIZE_E  = (BIT+1)'(SIZE);
  localparam logic [BIT:0] SIZE2_E = (BIT+1)'(2 * SIZE);
  localparam logic [BIT:0] XMAX_E  = (BIT+1)'(X_MAX);
  localparam logic [BIT:0] YMAX_E  = (BIT+1)'(Y_MAX);

  localparam logic [BIT-1:0] SIZE_B = BIT'(SIZE);
  localparam logic [BIT-1:0] XS_B   = BIT'(X_START);
  localparam logic [BIT-1:0] YS_B   = BIT'(Y_START);

  localparam logic [2:0] DIR_STOP  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_RIGHT = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DEAD = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [BIT-1:0] x_q, x_d, y_q, y_d;
  logic [2:0]     dir_q, dir_d, pend_q, pend_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           step_q, step_d;
  logic           running_q, running_d;
  logic           over_q, over_d;

  logic [2:0]     req_dir;
  logic           req_ok;
  logic [2:0]     step_dir;
  logic           hit;
  logic [BIT-1:0] mv_x, mv_y;

  function automatic logic [2:0] opposite_dir(input logic [2:0] d);
    case (d)
      DIR_UP:    return DIR_DOWN;
      DIR_DOWN:  return DIR_UP;
      DIR_LEFT:  return DIR_RIGHT;
      DIR_RIGHT: return DIR_LEFT;
      default:   return DIR_STOP;
    endcase
  endfunction

  // Only the highest-priority button is considered; if it is illegal the
  // lower-priority buttons are not consulted.
  always_comb begin
    req_dir = DIR_STOP;
    if (btn_up)         req_dir = DIR_UP;
    else if (btn_down)  req_dir = DIR_DOWN;
    else if (btn_left)  req_dir = DIR_LEFT;
    else if (btn_right) req_dir = DIR_RIGHT;
  end

  assign req_ok   = (req_dir != DIR_STOP) && (req_dir != dir_q) &&
                    (req_dir != opposite_dir(dir_q));
  // A request accepted in the step cycle itself takes effect on that step.
  assign step_dir = req_ok ? req_dir : pend_q;

  always_comb begin
    hit  = 1'b0;
    mv_x = x_q;
    mv_y = y_q;
    case (step_dir)
      DIR_UP: begin
        hit  = {1'b0, y_q} < SIZE_E;
        mv_y = y_q - SIZE_B;
      end
      DIR_DOWN: begin
        hit  = ({1'b0, y_q} + SIZE2_E) > YMAX_E;
        mv_y = y_q + SIZE_B;
      end
      DIR_LEFT: begin
        hit  = {1'b0, x_q} < SIZE_E;
        mv_x = x_q - SIZE_B;
      end
      DIR_RIGHT: begin
        hit  = ({1'b0, x_q} + SIZE2_E) > XMAX_E;
        mv_x = x_q + SIZE_B;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        x_d   = XS_B;
        y_d   = YS_B;
        dir_d = DIR_STOP;
        cnt_d = '0;
        if (req_ok) begin
          state_d = S_RUN;
          dir_d   = req_dir;
          pend_d  = req_dir;
        end else if (start) begin
          state_d = S_RUN;
          dir_d   = DIR_RIGHT;
          pend_d  = DIR_RIGHT;
        end
      end
      S_RUN: begin
        if (req_ok) pend_d = req_dir;
        if (frame_tick) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (hit) begin
              state_d = S_DEAD;
            end else begin
              x_d    = mv_x;
              y_d    = mv_y;
              dir_d  = step_dir;
              pend_d = step_dir;
              step_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_DEAD: begin
        if (start) begin
          state_d = S_IDLE;
          x_d     = XS_B;
          y_d     = YS_B;
          dir_d   = DIR_STOP;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    running_d = (state_d == S_RUN);
    over_d    = (state_d == S_DEAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      x_q       <= XS_B;
      y_q       <= YS_B;
      dir_q     <= DIR_STOP;
      pend_q    <= DIR_STOP;
      cnt_q     <= '0;
      step_q    <= 1'b0;
      running_q <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dir_q     <= dir_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      running_q <= running_d;
      over_q    <= over_d;
    end
  end

  assign head_x    = x_q;
  assign head_y    = y_q;
  assign direction = dir_q;
  assign step      = step_q;
  assign running   = running_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_snake_ctrl.sv
// tb/tb_snake_ctrl.sv - self-checking bench for snake_ctrl
module tb_snake_ctrl;

  localparam int SIZE = 25;
  localparam int BIT  = 10;
  localparam int XS   = 300;
  localparam int YS   = 300;
  localparam int XM   = 640;
  localparam int YM   = 480;
  localparam int TPS  = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           frame_tick = 1'b0, start = 1'b0;
  logic           btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [BIT-1:0] head_x, head_y;
  logic [2:0]     direction;
  logic           step, running, game_over;

  int checks   = 0;
  int failures = 0;

  snake_ctrl #(
    .SIZE(SIZE), .BIT(BIT), .X_START(XS), .Y_START(YS),
    .X_MAX(XM), .Y_MAX(YM), .TICKS_PER_STEP(TPS)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .head_x(head_x), .head_y(head_y), .direction(direction),
    .step(step), .running(running), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Reference model: game mode 0 idle, 1 run, 2 dead.
  int m_mode, m_x, m_y, m_dir, m_pend, m_cnt, m_step;
  int dxs[5] = '{0, 0, 0, -1, 1};
  int dys[5] = '{0, -1, 1, 0, 0};

  function automatic int opp(input int d);
    if (d == 1) return 2;
    if (d == 2) return 1;
    if (d == 3) return 4;
    if (d == 4) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_x = XS; m_y = YS; m_dir = 0; m_pend = 0; m_cnt = 0; m_step = 0;
  endtask

  task automatic model_step(input bit st, input bit tk, input bit u, input bit d,
                            input bit l, input bit r);
    int req, nx, ny, sd;
    bit acc;
    req = u ? 1 : d ? 2 : l ? 3 : r ? 4 : 0;
    acc = (req != 0) && (req != m_dir) && (req != opp(m_dir));
    m_step = 0;
    if (m_mode == 0) begin
      m_cnt = 0;
      if (acc) begin m_mode = 1; m_dir = req; m_pend = req; end
      else if (st) begin m_mode = 1; m_dir = 4; m_pend = 4; end
    end else if (m_mode == 1) begin
      if (acc) m_pend = req;
      if (tk) begin
        m_cnt++;
        if (m_cnt == TPS) begin
          m_cnt = 0;
          sd = m_pend;
          nx = m_x + dxs[sd] * SIZE;
          ny = m_y + dys[sd] * SIZE;
          // The head's next cell must lie wholly inside the playfield.
          if (nx >= 0 && nx + SIZE <= XM && ny >= 0 && ny + SIZE <= YM) begin
            m_x = nx; m_y = ny; m_dir = sd; m_step = 1;
          end else begin
            m_mode = 2;
          end
        end
      end
    end else if (st) begin
      m_mode = 0; m_x = XS; m_y = YS; m_dir = 0; m_cnt = 0;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string p, input int ex, input int ey, input int ed,
                         input int es, input int er, input int eg);
    chk({p, ".head_x"}, int'(head_x), ex);
    chk({p, ".head_y"}, int'(head_y), ey);
    chk({p, ".direction"}, int'(direction), ed);
    chk({p, ".step"}, int'(step), es);
    chk({p, ".running"}, int'(running), er);
    chk({p, ".game_over"}, int'(game_over), eg);
  endtask

  task automatic set_in(input bit st, input bit tk, input bit u, input bit d,
                        input bit l, input bit r);
    start = st; frame_tick = tk; btn_up = u; btn_down = d; btn_left = l; btn_right = r;
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    clk1();
    rst = 1'b0;
  endtask

  typedef struct {
    bit r, st, tk, u, d, l, rt;
    int reps;
    int ex, ey, edir, estep, erun, ego;
  } vec_t;

  vec_t tbl[13];

  initial begin
    // Wall run to the left edge, death, freeze, restart and reversal filtering.
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0,  1, 300, 300, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0,  3, 300, 300, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 1, 0,  1, 300, 300, 3, 0, 1, 0};
    tbl[3]  = '{0, 0, 1, 0, 0, 0, 0,  7, 300, 300, 3, 0, 1, 0};
    tbl[4]  = '{0, 0, 1, 0, 0, 0, 0,  1, 275, 300, 3, 1, 1, 0};
    tbl[5]  = '{0, 0, 1, 0, 0, 0, 0, 88,   0, 300, 3, 1, 1, 0};
    tbl[6]  = '{0, 0, 1, 0, 0, 0, 0,  8,   0, 300, 3, 0, 0, 1};
    tbl[7]  = '{0, 0, 1, 1, 0, 0, 1, 10,   0, 300, 3, 0, 0, 1};
    tbl[8]  = '{0, 1, 0, 0, 0, 0, 0,  1, 300, 300, 0, 0, 0, 0};
    tbl[9]  = '{0, 0, 0, 1, 0, 0, 0,  1, 300, 300, 1, 0, 1, 0};
    tbl[10] = '{0, 0, 0, 0, 1, 0, 0,  1, 300, 300, 1, 0, 1, 0};
    tbl[11] = '{0, 0, 1, 0, 0, 0, 0,  8, 300, 275, 1, 1, 1, 0};
    tbl[12] = '{0, 1, 1, 0, 0, 0, 0,  8, 300, 250, 1, 1, 1, 0};

    // Reset state.
    do_reset();
    chk_all("reset", 300, 300, 0, 0, 0, 0);

    // Step rate: ticks spaced 10 cycles apart, one step after the 8th.
    start = 1'b1;
    clk1();
    start = 1'b0;
    chk_all("rate.start", 300, 300, 4, 0, 1, 0);
    for (int k = 1; k <= 8; k++) begin
      frame_tick = 1'b1;
      clk1();
      frame_tick = 1'b0;
      if (k < 8) chk_all("rate.nostep", 300, 300, 4, 0, 1, 0);
      else       chk_all("rate.step", 325, 300, 4, 1, 1, 0);
      for (int j = 0; j < 9; j++) begin
        clk1();
        chk("rate.quiet.step", int'(step), 0);
      end
    end

    // Advance to (350,300) then assert rst between edges.
    frame_tick = 1'b1;
    repeat (8) clk1();
    frame_tick = 1'b0;
    chk_all("pre_async", 350, 300, 4, 1, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 300, 300, 0, 0, 0, 0);
    clk1();
    rst = 1'b0;

    // Reversal is discarded; up beats right.
    do_reset();
    start = 1'b1;
    clk1();
    start = 1'b0;
    set_in(0, 1, 0, 0, 1, 0);
    repeat (8) clk1();
    chk_all("reverse", 325, 300, 4, 1, 1, 0);
    set_in(0, 1, 1, 0, 0, 1);
    repeat (8) clk1();
    chk_all("priority", 325, 275, 1, 1, 1, 0);
    set_in(0, 0, 0, 0, 0, 0);

    // Request in the terminal-tick cycle steers that step.
    do_reset();
    start = 1'b1;
    clk1();
    start = 1'b0;
    frame_tick = 1'b1;
    repeat (7) clk1();
    btn_down = 1'b1;
    clk1();
    set_in(0, 0, 0, 0, 0, 0);
    chk_all("same_cycle", 300, 325, 2, 1, 1, 0);
    clk1();
    chk("same_cycle.pulse_end", int'(step), 0);

    // Table-driven vectors.
    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].r;
      set_in(tbl[i].st, tbl[i].tk, tbl[i].u, tbl[i].d, tbl[i].l, tbl[i].rt);
      repeat (tbl[i].reps) clk1();
      chk_all($sformatf("tbl%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].edir,
              tbl[i].estep, tbl[i].erun, tbl[i].ego);
      rst = 1'b0;
      set_in(0, 0, 0, 0, 0, 0);
    end

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      bit st, tk, u, d, l, r;
      st = ($urandom_range(0, 29) == 0);
      tk = ($urandom_range(0, 1) == 0);
      u  = ($urandom_range(0, 5) == 0);
      d  = ($urandom_range(0, 5) == 0);
      l  = ($urandom_range(0, 5) == 0);
      r  = ($urandom_range(0, 5) == 0);
      set_in(st, tk, u, d, l, r);
      if ($urandom_range(0, 699) == 0) begin
        rst = 1'b1;
        model_reset();
      end else begin
        model_step(st, tk, u, d, l, r);
      end
      clk1();
      rst = 1'b0;
      chk_all("rnd", m_x, m_y, m_dir, m_step, (m_mode == 1) ? 1 : 0, (m_mode == 2) ? 1 : 0);
    end
    set_in(0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
